sdram_arbiter: RTL

- Shares the single SDRAM controller command/data port between N_REQ requesters (CPU, PPU, APU DMA, video scan-out).
- Each grant owns the controller for exactly one burst of BURST_LEN beats, read or write.
- Round-robin arbitration between bursts.
- Steers write beats from the owner to the controller and read beats from the controller back to the owner.

---
 rtl/sdram_pkg.sv | 30 +++
 rtl/sdram_arbiter_rr_arbiter.sv | 45 ++++
 rtl/sdram_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// ============================================================================
// Module      : sdram_pkg
// Description : Shared types and defaults for the SDRAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sdram_pkg;

    // Arbiter sequencing: pick a winner, issue its command, move its beats.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    localparam int SDRAM_BURST_LEN = 8;
    localparam int SDRAM_DATA_W    = 16;
    localparam int SDRAM_ADDR_W    = 24;

    // Beat counter is never narrower than 3 bits so short bursts still count cleanly.
    function automatic int cnt_width(input int burst_len);
        int w;
        w = $clog2(burst_len);
        return (w < 3) ? 3 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sdram_arbiter_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Grants the first asserted
//               request at or after the pointer, wrapping modulo N_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx
);

    // Scan from the pointer upward, wrapping, and keep the first hit.
    always_comb begin
        logic           found;
        int             pos;
        logic [IDX_W-1:0] sel;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        sel   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = int'(ptr) + i;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            sel = IDX_W'(pos);
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                idx        = sel;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sdram_arbiter.sv
// ============================================================================
// Module      : sdram_arbiter
// Description : Shares one SDRAM controller port between N_REQ requesters.
//               Each grant owns the controller for one BURST_LEN-beat burst.
//               Optional macro SDRAM_ARB_PRIO_EN gives requester 0 (video
//               scan-out) fixed top priority; others round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = SDRAM_ADDR_W,
    parameter int DATA_W    = SDRAM_DATA_W,
    parameter int BURST_LEN = SDRAM_BURST_LEN
) (
    input  logic                      clk_sys,
    input  logic                      reset_sys,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*DATA_W-1:0]   wr_data,
    output logic [N_REQ-1:0]          wr_ack,
    output logic [DATA_W-1:0]         rd_data,
    output logic [N_REQ-1:0]          rd_valid,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_wack,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_rvalid
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = cnt_width(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

    arb_state_t        state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  owner;
    logic [CNT_W-1:0]  beat_cnt;

    logic [ADDR_W-1:0] addr_arr [N_REQ];
    logic [DATA_W-1:0] wdata_arr [N_REQ];

    logic [N_REQ-1:0]  pick_req;
    logic [N_REQ-1:0]  pick_grant;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  win_idx;
    logic              win_any;
    logic              beat;
    logic              keep_ptr;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = wr_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

`ifdef SDRAM_ARB_PRIO_EN
    // Requester 0 bypasses the rotation; the rest share the round-robin.
    assign pick_req = req_valid & {{(N_REQ-1){1'b1}}, 1'b0};
    assign win_idx  = req_valid[0] ? '0 : pick_idx;
    assign win_any  = req_valid[0] | (|pick_grant);
    assign keep_ptr = (owner == '0);
`else
    assign pick_req = req_valid;
    assign win_idx  = pick_idx;
    assign win_any  = |pick_grant;
    assign keep_ptr = 1'b0;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .req   (pick_req),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // A beat counts only in DATA and only in the burst's own direction.
    assign beat      = (state == DATA) && (mem_we ? mem_wack : mem_rvalid);
    assign mem_wdata = wdata_arr[owner];
    assign rd_data   = mem_rdata;

    // Steer the accept pulse and beat strobes to the current owner only.
    always_comb begin
        req_ready = '0;
        wr_ack    = '0;
        rd_valid  = '0;
        if (state == CMD && mem_valid && mem_ready) begin
            req_ready[owner] = 1'b1;
        end
        if (state == DATA) begin
            wr_ack[owner]   = mem_wack && mem_we;
            rd_valid[owner] = mem_rvalid && !mem_we;
        end
    end

    // Burst sequencer: arbitrate, hold the command until accepted, count beats.
    always_ff @(posedge clk_sys or posedge reset_sys) begin
        if (reset_sys) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            beat_cnt  <= '0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        owner     <= win_idx;
                        mem_we    <= req_we[win_idx];
                        mem_addr  <= addr_arr[win_idx];
                        mem_valid <= 1'b1;
                        state     <= CMD;
                    end
                end
                CMD: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        beat_cnt  <= '0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            state    <= IDLE;
                            if (!keep_ptr) begin
                                rr_ptr <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
